// File: rtl/bf_loader_if.sv
// bf_loader_if: character stream and instruction-memory write port of the
// Brainfuck program loader.
//   char_in/char_valid_in/char_last_in : source character stream (producer -> loader)
//   char_ready_out                     : loader accepts a character this cycle
//   mem_we_out/mem_addr_out/mem_data_out : opcode write strobe, address, 3-bit opcode
// master = character source / memory side, slave = the loader.
interface bf_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        char_in;
  logic              char_valid_in;
  logic              char_last_in;
  logic              char_ready_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [2:0]        mem_data_out;

  modport master (
    output char_in, char_valid_in, char_last_in,
    input  char_ready_out, mem_we_out, mem_addr_out, mem_data_out
  );

  modport slave (
    input  char_in, char_valid_in, char_last_in,
    output char_ready_out, mem_we_out, mem_addr_out, mem_data_out
  );
endinterface

// File: rtl/bf_loader.sv
// bf_loader: parses an ASCII Brainfuck source stream, writes one 3-bit opcode
// per command character into instruction memory, checks bracket balance and
// capacity, and releases the CPU only after an error-free load.
// Ports:
//   clk_in        : clock, rising edge
//   reset_in      : asynchronous active-low reset
//   start_in      : one-cycle pulse starting a new load (ignored while busy)
//   bus           : character stream in / memory write port out (bf_loader_if.slave)
//   prog_len_out  : number of opcodes stored by the last successful load
//   busy_out, done_out, err_out : status levels
//   err_code_out  : 0 none, 1 unmatched ']', 2 unclosed '[', 3 capacity exceeded
//   cpu_run_out   : high while in DONE
module bf_loader #(
  parameter int ADDR_W  = 16,
  parameter int MAX_LEN = 65535,
  parameter int DEPTH_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  bf_loader_if.slave        bus,
  output logic [ADDR_W-1:0] prog_len_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
  output logic [1:0]        err_code_out,
  output logic              cpu_run_out
);

  typedef enum logic [2:0] {IDLE, LOAD, FINISH, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0]  CAP       = ADDR_W'(MAX_LEN);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   count, count_nx;
  logic [ADDR_W-1:0]   prog_len, prog_len_nx;
  logic [DEPTH_W-1:0]  depth, depth_nx;
  logic [1:0]          err_code, err_code_nx;
  logic                we_p1, we_nx;
  logic [ADDR_W-1:0]   addr_p1, addr_nx;
  logic [2:0]          data_p1, data_nx;
  logic                is_cmd;
  logic [2:0]          op;
  logic                accept;

  // Returns {is_command, opcode}; any other byte is a comment character.
  function automatic logic [3:0] decode(input logic [7:0] c);
    case (c)
      8'h2B:   decode = 4'b1_000; // +
      8'h2D:   decode = 4'b1_001; // -
      8'h3E:   decode = 4'b1_010; // >
      8'h3C:   decode = 4'b1_011; // <
      8'h5B:   decode = 4'b1_100; // [
      8'h5D:   decode = 4'b1_101; // ]
      8'h2E:   decode = 4'b1_110; // .
      8'h2C:   decode = 4'b1_111; // ,
      default: decode = 4'b0_000;
    endcase
  endfunction

  always_comb begin
    {is_cmd, op} = decode(bus.char_in);
    accept       = (state == LOAD) && bus.char_valid_in;
    state_nx     = state;
    count_nx     = count;
    prog_len_nx  = prog_len;
    depth_nx     = depth;
    err_code_nx  = err_code;
    we_nx        = 1'b0;
    addr_nx      = '0;
    data_nx      = '0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_in) begin
          state_nx    = LOAD;
          count_nx    = '0;
          depth_nx    = '0;
          err_code_nx = 2'd0;
          prog_len_nx = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          // Errors are checked before char_last_in so a bad final
          // character never reaches FINISH.
          if (is_cmd) begin
            if (op == 3'd5 && depth == '0) begin
              state_nx    = ERR;
              err_code_nx = 2'd1;
            end else if (count == CAP || (op == 3'd4 && depth == DEPTH_MAX)) begin
              state_nx    = ERR;
              err_code_nx = 2'd3;
            end else begin
              we_nx    = 1'b1;
              addr_nx  = count;
              data_nx  = op;
              count_nx = count + 1'b1;
              if (op == 3'd4) depth_nx = depth + 1'b1;
              if (op == 3'd5) depth_nx = depth - 1'b1;
              if (bus.char_last_in) state_nx = FINISH;
            end
          end else if (bus.char_last_in) begin
            state_nx = FINISH;
          end
        end
      end
      FINISH: begin
        if (depth == '0) begin
          state_nx    = DONE;
          prog_len_nx = count;
        end else begin
          state_nx    = ERR;
          err_code_nx = 2'd2;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p1: registered state and the memory write issued one cycle after acceptance.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state    <= IDLE;
      count    <= '0;
      prog_len <= '0;
      depth    <= '0;
      err_code <= 2'd0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      prog_len <= prog_len_nx;
      depth    <= depth_nx;
      err_code <= err_code_nx;
      we_p1    <= we_nx;
      addr_p1  <= addr_nx;
      data_p1  <= data_nx;
    end
  end

  assign bus.char_ready_out = (state == LOAD);
  assign bus.mem_we_out     = we_p1;
  assign bus.mem_addr_out   = addr_p1;
  assign bus.mem_data_out   = data_p1;
  assign prog_len_out       = prog_len;
  assign busy_out           = (state == LOAD) || (state == FINISH);
  assign done_out           = (state == DONE);
  assign err_out            = (state == ERR);
  assign err_code_out       = err_code;
  assign cpu_run_out        = (state == DONE);

endmodule

// File: tb/tb_bf_loader.sv
module tb_bf_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic start [2];
  logic valid [2];
  logic last  [2];
  logic [7:0] ch [2];

  logic rdy [2];
  logic we [2];
  logic [15:0] addr [2];
  logic [2:0] data [2];
  logic [15:0] plen [2];
  logic busy [2];
  logic done [2];
  logic err [2];
  logic [1:0] code [2];
  logic cpu [2];

  int total = 0;
  int bad   = 0;
  int got0[$];
  int got1[$];

  always #5 clk = ~clk;

  bf_loader_if #(.ADDR_W(16)) b0 ();
  bf_loader_if #(.ADDR_W(16)) b1 ();

  assign b0.char_in = ch[0];
  assign b0.char_valid_in = valid[0];
  assign b0.char_last_in = last[0];
  assign b1.char_in = ch[1];
  assign b1.char_valid_in = valid[1];
  assign b1.char_last_in = last[1];
  assign rdy[0] = b0.char_ready_out;
  assign rdy[1] = b1.char_ready_out;
  assign we[0] = b0.mem_we_out;
  assign we[1] = b1.mem_we_out;
  assign addr[0] = b0.mem_addr_out;
  assign addr[1] = b1.mem_addr_out;
  assign data[0] = b0.mem_data_out;
  assign data[1] = b1.mem_data_out;

  bf_loader #(.ADDR_W(16), .MAX_LEN(65535), .DEPTH_W(8)) dut0 (
    .clk_in(clk), .reset_in(rst_n), .start_in(start[0]), .bus(b0.slave),
    .prog_len_out(plen[0]), .busy_out(busy[0]), .done_out(done[0]),
    .err_out(err[0]), .err_code_out(code[0]), .cpu_run_out(cpu[0])
  );

  bf_loader #(.ADDR_W(16), .MAX_LEN(4), .DEPTH_W(2)) dut1 (
    .clk_in(clk), .reset_in(rst_n), .start_in(start[1]), .bus(b1.slave),
    .prog_len_out(plen[1]), .busy_out(busy[1]), .done_out(done[1]),
    .err_out(err[1]), .err_code_out(code[1]), .cpu_run_out(cpu[1])
  );

  // Write capture: one sample per strobe cycle, mid-cycle.
  always @(negedge clk) begin
    if (b0.mem_we_out === 1'b1) got0.push_back(int'(b0.mem_addr_out) * 8 + int'(b0.mem_data_out));
    if (b1.mem_we_out === 1'b1) got1.push_back(int'(b1.mem_addr_out) * 8 + int'(b1.mem_data_out));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int opcode(input byte c);
    case (c)
      "+": return 0;
      "-": return 1;
      ">": return 2;
      "<": return 3;
      "[": return 4;
      "]": return 5;
      ".": return 6;
      ",": return 7;
      default: return -1;
    endcase
  endfunction

  // Reference: walk the source, list expected writes and the final outcome.
  // fin: 0 still loading, 1 DONE, 2 ERR. used: characters the loader consumes.
  function automatic void model(input byte s[$], input bit has_last, input int max_len,
                                input int dmax, output int wq[$], output int fin,
                                output int ecode, output int len, output int used);
    int cnt = 0;
    int dep = 0;
    wq = {};
    fin = 0; ecode = 0; len = 0; used = 0;
    for (int i = 0; i < s.size(); i++) begin
      int op = opcode(s[i]);
      used++;
      if (op >= 0) begin
        if (op == 5 && dep == 0) begin fin = 2; ecode = 1; return; end
        if (cnt == max_len || (op == 4 && dep == dmax)) begin fin = 2; ecode = 3; return; end
        wq.push_back(cnt * 8 + op);
        cnt++;
        if (op == 4) dep++;
        if (op == 5) dep--;
      end
      if (has_last && i == s.size() - 1) begin
        if (dep == 0) begin fin = 1; len = cnt; end
        else begin fin = 2; ecode = 2; end
        return;
      end
    end
  endfunction

  function automatic void str2q(input string s, output byte q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  function automatic byte pick();
    string cmds = "+-><[].,";
    string noise = "ab \n9Z";
    if ($urandom_range(0, 4) == 0) return noise[$urandom_range(0, 5)];
    return cmds[$urandom_range(0, 7)];
  endfunction

  task automatic feed(input int u, input byte s[$], input bit has_last, input bit gaps,
                      input bit mid_start, output int fed);
    fed = 0;
    for (int i = 0; i < s.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        int n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          ch[u] = 8'($urandom_range(0, 255));
          valid[u] = 1'b0;
          @(posedge clk); #1;
        end
      end
      if (mid_start && i == 1) begin
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
      end
      if (rdy[u] !== 1'b1) break;
      ch[u] = s[i];
      valid[u] = 1'b1;
      last[u] = has_last && (i == s.size() - 1);
      @(posedge clk); #1;
      valid[u] = 1'b0;
      last[u] = 1'b0;
      fed++;
    end
  endtask

  task automatic run(input int u, input string tag, input byte s[$], input bit has_last,
                     input bit gaps, input bit mid_start);
    int wq[$];
    int fin, ecode, len, used, fed, n;
    int ml = (u == 0) ? 65535 : 4;
    int dm = (u == 0) ? 255 : 3;
    model(s, has_last, ml, dm, wq, fin, ecode, len, used);
    if (u == 0) got0.delete(); else got1.delete();
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    chk({tag, " busy_at_start"}, busy[u], 1);
    chk({tag, " plen_cleared"}, plen[u], 0);
    chk({tag, " code_cleared"}, code[u], 0);
    feed(u, s, has_last, gaps, mid_start, fed);
    chk({tag, " consumed"}, fed, used);
    if (fin == 1 || (fin == 2 && ecode == 2)) begin
      chk({tag, " finish_busy"}, busy[u], 1);
      chk({tag, " finish_done"}, done[u], 0);
      chk({tag, " finish_err"}, err[u], 0);
      @(posedge clk); #1;
    end
    chk({tag, " done"}, done[u], fin == 1);
    chk({tag, " err"}, err[u], fin == 2);
    chk({tag, " err_code"}, code[u], ecode);
    chk({tag, " prog_len"}, plen[u], len);
    chk({tag, " cpu_run"}, cpu[u], fin == 1);
    chk({tag, " ready"}, rdy[u], fin == 0);
    @(posedge clk); #1;
    n = (u == 0) ? got0.size() : got1.size();
    chk({tag, " n_writes"}, n, wq.size());
    for (int i = 0; i < wq.size() && i < n; i++) begin
      int g = (u == 0) ? got0[i] : got1[i];
      chk($sformatf("%s write%0d", tag, i), g, wq[i]);
    end
  endtask

  initial begin
    byte q[$];
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; valid[u] = 1'b0; last[u] = 1'b0; ch[u] = 8'h00;
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst%0d ready", u), rdy[u], 0);
      chk($sformatf("rst%0d we", u), we[u], 0);
      chk($sformatf("rst%0d busy", u), busy[u], 0);
      chk($sformatf("rst%0d done", u), done[u], 0);
      chk($sformatf("rst%0d err", u), err[u], 0);
      chk($sformatf("rst%0d code", u), code[u], 0);
      chk($sformatf("rst%0d plen", u), plen[u], 0);
      chk($sformatf("rst%0d cpu", u), cpu[u], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_rst busy", busy[0], 0);
    chk("idle_after_rst ready", rdy[0], 0);

    str2q("+[->+<]", q);      run(0, "loop", q, 1, 0, 0);
    str2q("a+ b\n-", q);      run(0, "comments", q, 1, 1, 0);
    str2q("+]", q);           run(0, "unmatched", q, 0, 0, 0);
    str2q("[[+]", q);         run(0, "unclosed", q, 1, 0, 0);
    str2q("+++++", q);        run(1, "capacity", q, 0, 0, 0);
    str2q("xyz", q);          run(0, "empty", q, 1, 0, 0);
    str2q("[[[[", q);         run(1, "depth_ovf", q, 1, 0, 0);
    str2q("]", q);            run(0, "err_over_last", q, 1, 0, 0);
    str2q("++", q);           run(0, "start_ignored", q, 1, 0, 1);
    str2q("+-.,", q);         run(1, "exact_cap", q, 1, 0, 0);

    for (int it = 0; it < 25; it++) begin
      for (int u = 0; u < 2; u++) begin
        int n = $urandom_range(1, 24);
        q.delete();
        for (int k = 0; k < n; k++) q.push_back(pick());
        run(u, $sformatf("rnd%0d_u%0d", it, u), q, 1, 1, 0);
      end
    end

    // Reset in the middle of a load, after an input stall.
    got0.delete();
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    str2q("++", q);
    begin
      int fed;
      feed(0, q, 0, 0, 0, fed);
    end
    valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall ready", rdy[0], 1);
    chk("stall busy", busy[0], 1);
    chk("stall n_writes", got0.size(), 2);
    chk("stall write1", got0.size() > 1 ? got0[1] : -1, 8);
    ch[0] = "+";
    valid[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async ready", rdy[0], 0);
    chk("async we", we[0], 0);
    chk("async addr", addr[0], 0);
    chk("async data", data[0], 0);
    chk("async busy", busy[0], 0);
    chk("async done", done[0], 0);
    chk("async err", err[0], 0);
    chk("async code", code[0], 0);
    chk("async plen", plen[0], 0);
    chk("async cpu", cpu[0], 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst busy", busy[0], 0);
    chk("post_rst ready", rdy[0], 0);
    chk("post_rst n_writes", got0.size(), 2);
    valid[0] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bf_loader.md
BF_LOADER -- requirements
Module: bf_loader

Interface
REQ-001 Parameter ADDR_W, default 16, instruction memory address width.
REQ-002 Parameter MAX_LEN, default 65535, maximum number of stored opcodes.
REQ-003 Parameter DEPTH_W, default 8, bracket nesting counter width.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 reset_in  input  1  reset, asynchronous, active-low.
REQ-006 start_in  input  1  one-cycle pulse; begins a new program load.
REQ-007 char_in  input  8  ASCII source character.
REQ-008 char_valid_in  input  1  char_in valid.
REQ-009 char_last_in  input  1  marks char_in as the final character; qualified by char_valid_in.
REQ-010 char_ready_out  output  1  loader accepts a character this cycle.
REQ-011 mem_we_out  output  1  instruction memory write strobe.
REQ-012 mem_addr_out  output  ADDR_W  instruction memory write address.
REQ-013 mem_data_out  output  3  opcode: 0 '+', 1 '-', 2 '>', 3 '<', 4 '[', 5 ']', 6 '.', 7 ','.
REQ-014 prog_len_out  output  ADDR_W  number of opcodes stored.
REQ-015 busy_out, done_out, err_out  output  1 each  loader status levels.
REQ-016 err_code_out  output  2  0 none, 1 unmatched ']', 2 unclosed '[', 3 capacity exceeded.
REQ-017 cpu_run_out  output  1  high only when a load completed without error; releases the CPU.

Function
REQ-018 FSM states: IDLE, LOAD, FINISH, DONE, ERR.
REQ-019 IDLE/DONE/ERR + start_in -> LOAD; count, depth, err_code, prog_len cleared on that edge.
REQ-020 start_in in LOAD or FINISH is ignored.
REQ-021 char_ready_out = 1 only in LOAD; a character is accepted when char_valid_in && char_ready_out.
REQ-022 Accepted command character: mem_we_out = 1 for exactly the next cycle, with mem_addr_out = count before increment and mem_data_out = opcode; count increments by 1.
REQ-023 Accepted non-command character (any byte other than the eight commands): consumed, no write, count unchanged.
REQ-024 '[' increments depth; ']' decrements depth.
REQ-025 ']' accepted with depth 0 -> ERR, err_code 1, no write.
REQ-026 Command character accepted with count == MAX_LEN, or '[' with depth == 2^DEPTH_W-1 -> ERR, err_code 3, no write.
REQ-027 Accepted character with char_last_in = 1 and no error -> FINISH (its write, if any, occurs during FINISH).
REQ-028 FINISH -> DONE if depth == 0, else ERR with err_code 2; exactly one cycle in FINISH.
REQ-029 prog_len_out updates to the final count on entry to DONE and holds until the next start_in or reset.
REQ-030 busy_out = 1 in LOAD and FINISH; done_out = 1 in DONE; err_out = 1 in ERR; cpu_run_out = done_out.
REQ-031 mem_we_out is never asserted outside the cycle following an accepted command character.
REQ-032 Error detection takes priority over char_last_in on the same character.
REQ-033 A program with zero command characters is valid: DONE with prog_len 0.

Reset
REQ-034 reset_in low forces IDLE immediately, regardless of clock; all outputs 0, count 0, depth 0.
REQ-035 Reset during LOAD abandons the load; no further writes; prior memory contents are not cleared.
REQ-036 After reset_in rises, loader stays in IDLE until start_in.

Verification
REQ-037 start, "+[->+<]" with last on ']' -> 7 writes, addr 0..6, data 0,4,1,2,0,3,5; DONE, prog_len 7, cpu_run 1.
REQ-038 start, "a+ b\n-" with last on '-' -> 2 writes (addr 0 data 0, addr 1 data 1); prog_len 2.
REQ-039 start, "+]" -> write addr 0 only; ERR, err_code 1, char_ready 0 after ']'.
REQ-040 start, "[[+]" with last on ']' -> 4 writes; FINISH then ERR, err_code 2, cpu_run 0.
REQ-041 MAX_LEN=4, start, "+++++" -> 4 writes; fifth '+' gives ERR, err_code 3.
REQ-042 Hold char_valid low 3 cycles mid-load, then reset_in low during LOAD -> outputs 0 asynchronously, IDLE, no write after reset.
